// File: rtl/step_sequencer_if.sv
// Control-unit side of the step sequencer: run/halt/restart/load controls in,
// decoder select and enables out.
interface step_sequencer_if;
  logic       START;
  logic       HLT;
  logic       RESUME;
  logic       SR;
  logic       N_PE;
  logic [2:0] D;
  logic [2:0] Q;
  logic       E3;
  logic       N_E;
  logic       TC;
  logic       RUNNING;

  modport master (
    output START, HLT, RESUME, SR, N_PE, D,
    input  Q, E3, N_E, TC, RUNNING
  );

  modport slave (
    input  START, HLT, RESUME, SR, N_PE, D,
    output Q, E3, N_E, TC, RUNNING
  );
endinterface

// File: rtl/step_sequencer.sv
// Microcode step sequencer feeding a 3->8 timing-step decoder.
// Optional parallel load is enabled by defining STEP_LOAD_EN.
//
// state | meaning
// IDLE  | after reset, decoder disabled, waiting for START
// RUN   | stepping, one decoder strobe per clock
// HOLD  | frozen by HLT, decoder disabled, waiting for RESUME
module step_sequencer #(
  parameter int unsigned LAST_STEP = 7
) (
  input logic CP,
  input logic MR,
  step_sequencer_if.slave bus
);

  localparam logic [2:0] LAST_Q = 3'(LAST_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] q, q_nxt;
  logic       load;

`ifdef STEP_LOAD_EN
  assign load = !bus.N_PE;
`else
  logic unused_load;
  assign unused_load = ^{bus.N_PE, bus.D};
  assign load = 1'b0;
`endif

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state <= IDLE;
      q     <= 3'd0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;

    case (state)
      IDLE:    if (bus.START) state_nxt = RUN;
      RUN:     if (bus.HLT) state_nxt = HOLD;
      HOLD:    if (bus.RESUME && !bus.HLT) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase

    // SR zeroes the step in every state, even alongside HLT.
    if (bus.SR) begin
      q_nxt = 3'd0;
    end else if (state == RUN && !bus.HLT) begin
      if (load)
        q_nxt = bus.D;
      else if (q >= LAST_Q)
        q_nxt = 3'd0;
      else
        q_nxt = q + 3'd1;
    end
  end

  assign bus.Q       = q;
  assign bus.E3      = (state == RUN);
  assign bus.N_E     = (state != RUN);
  assign bus.RUNNING = (state == RUN);
  assign bus.TC      = (state == RUN) && (q == LAST_Q);

`ifdef FORMAL
  always_comb begin
    assert (bus.N_E == !bus.E3);
    if (bus.E3) assert (state == RUN);
    if (bus.TC) assert (bus.E3);
    if (MR) assert (q == 3'd0);
`ifndef STEP_LOAD_EN
    assert (q <= LAST_Q);
`endif
  end
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench: two sequencers (LAST_STEP 7 and 4) share stimulus and are
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_step_sequencer;

  logic       CP = 1'b0;
  logic       MR = 1'b1;
  logic       start = 1'b0, hlt = 1'b0, resume = 1'b0, sr = 1'b0, n_pe = 1'b1;
  logic [2:0] d = 3'd0;

  int checks = 0;
  int errors = 0;

`ifdef STEP_LOAD_EN
  localparam bit LOAD_ON = 1'b1;
`else
  localparam bit LOAD_ON = 1'b0;
`endif

  always #5 CP = ~CP;

  step_sequencer_if bus0 ();
  step_sequencer_if bus1 ();

  assign bus0.START = start;  assign bus1.START = start;
  assign bus0.HLT = hlt;      assign bus1.HLT = hlt;
  assign bus0.RESUME = resume; assign bus1.RESUME = resume;
  assign bus0.SR = sr;        assign bus1.SR = sr;
  assign bus0.N_PE = n_pe;    assign bus1.N_PE = n_pe;
  assign bus0.D = d;          assign bus1.D = d;

  step_sequencer #(.LAST_STEP(7)) dut0 (.CP(CP), .MR(MR), .bus(bus0));
  step_sequencer #(.LAST_STEP(4)) dut1 (.CP(CP), .MR(MR), .bus(bus1));

  logic [2:0] q_a [2];
  logic       e3_a[2], ne_a[2], tc_a[2], run_a[2];
  assign q_a[0] = bus0.Q;   assign q_a[1] = bus1.Q;
  assign e3_a[0] = bus0.E3; assign e3_a[1] = bus1.E3;
  assign ne_a[0] = bus0.N_E; assign ne_a[1] = bus1.N_E;
  assign tc_a[0] = bus0.TC; assign tc_a[1] = bus1.TC;
  assign run_a[0] = bus0.RUNNING; assign run_a[1] = bus1.RUNNING;

  // Model: mode 0 = idle, 1 = running, 2 = held; step is the current count.
  int last[2] = '{7, 4};
  int mode[2] = '{0, 0};
  int step[2] = '{0, 0};

  always @(posedge CP or posedge MR) begin
    if (MR) begin
      for (int i = 0; i < 2; i++) begin
        mode[i] = 0;
        step[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int nm;
        int ns;
        nm = mode[i];
        ns = step[i];
        if (mode[i] == 0 && start) nm = 1;
        if (mode[i] == 1 && hlt) nm = 2;
        if (mode[i] == 2 && resume && !hlt) nm = 1;
        if (sr) ns = 0;
        else if (mode[i] == 1 && !hlt) begin
          if (LOAD_ON && !n_pe) ns = int'(d);
          else ns = (step[i] >= last[i]) ? 0 : step[i] + 1;
        end
        mode[i] = nm;
        step[i] = ns;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CP) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d_q", i), int'(q_a[i]), step[i]);
      check($sformatf("dut%0d_e3", i), int'(e3_a[i]), int'(mode[i] == 1));
      check($sformatf("dut%0d_n_e", i), int'(ne_a[i]), int'(mode[i] != 1));
      check($sformatf("dut%0d_tc", i), int'(tc_a[i]), int'(mode[i] == 1 && step[i] == last[i]));
      check($sformatf("dut%0d_running", i), int'(run_a[i]), int'(mode[i] == 1));
    end
  end

  task automatic tick();
    @(posedge CP);
    @(negedge CP);
  endtask

  task automatic wait_q0(input int target);
    for (int n = 0; n < 20 && step[0] != target; n++) tick();
    check("wait_q0", int'(q_a[0]), target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge CP);
    MR = 1'b0;
    check("rst_q", int'(q_a[0]), 0);
    check("rst_e3", int'(e3_a[0]), 0);
    check("rst_n_e", int'(ne_a[0]), 1);
    check("rst_tc", int'(tc_a[0]), 0);

    // Async reset mid-cycle while running
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("pre_mr_q", int'(q_a[0]), 2);
    #2 MR = 1'b1;
    #1;
    check("mr_q", int'(q_a[0]), 0);
    check("mr_e3", int'(e3_a[0]), 0);
    check("mr_n_e", int'(ne_a[0]), 1);
    check("mr_tc", int'(tc_a[0]), 0);
    #1 MR = 1'b0;
    @(negedge CP);

    // Full sequences for both LAST_STEP values
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("seq7_q", int'(q_a[0]), k % 8);
      check("seq7_tc", int'(tc_a[0]), int'(k == 7));
      check("seq7_e3", int'(e3_a[0]), 1);
      check("seq4_q", int'(q_a[1]), k % 5);
      check("seq4_tc", int'(tc_a[1]), int'(k % 5 == 4));
      tick();
    end

    // Halt / resume
    wait_q0(3);
    hlt = 1'b1; tick();
    check("hlt_q", int'(q_a[0]), 3);
    check("hlt_e3", int'(e3_a[0]), 0);
    resume = 1'b1; tick();
    check("hlt_res_q", int'(q_a[0]), 3);
    check("hlt_res_e3", int'(e3_a[0]), 0);
    hlt = 1'b0; tick();
    check("res_q", int'(q_a[0]), 3);
    check("res_e3", int'(e3_a[0]), 1);
    resume = 1'b0; tick();
    check("res_next_q", int'(q_a[0]), 4);

    // Step restart
    wait_q0(5);
    sr = 1'b1; tick(); sr = 1'b0;
    check("sr_q", int'(q_a[0]), 0);
    tick();
    sr = 1'b1; n_pe = 1'b0; d = 3'd6; tick();
    sr = 1'b0; n_pe = 1'b1; d = 3'd0;
    check("sr_load_q0", int'(q_a[0]), 0);
    check("sr_load_q1", int'(q_a[1]), 0);

    // Parallel load
    n_pe = 1'b0; d = 3'd2; tick(); n_pe = 1'b1;
    check("load_q", int'(q_a[0]), LOAD_ON ? 2 : 1);
    tick();
    check("load_next_q", int'(q_a[0]), LOAD_ON ? 3 : 2);
    hlt = 1'b1; tick(); hlt = 1'b0;
    n_pe = 1'b0; d = 3'd5; tick(); n_pe = 1'b1;
    check("hold_load_q", int'(q_a[0]), LOAD_ON ? 3 : 2);
    check("hold_load_e3", int'(e3_a[0]), 0);
    resume = 1'b1; tick(); resume = 1'b0;
    check("load_res_e3", int'(e3_a[0]), 1);

    // Reset mid-RUN
    wait_q0(6);
    #2 MR = 1'b1;
    #1;
    check("mr_run_q", int'(q_a[0]), 0);
    check("mr_run_running", int'(run_a[0]), 0);
    check("mr_run_e3", int'(e3_a[0]), 0);
    @(negedge CP);
    MR = 1'b0;
    tick();
    check("post_mr_idle", int'(run_a[0]), 0);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_q", int'(q_a[0]), 0);
    check("restart_e3", int'(e3_a[0]), 1);
    tick();
    check("restart_next_q", int'(q_a[0]), 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      start  = ($urandom_range(7) == 0);
      hlt    = ($urandom_range(7) == 0);
      resume = ($urandom_range(3) == 0);
      sr     = ($urandom_range(15) == 0);
      n_pe   = !($urandom_range(7) == 0);
      d      = 3'($urandom_range(7));
      if ($urandom_range(199) == 0) begin
        #1 MR = 1'b1;
        #2 MR = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
